// File: rtl/multich_xfer_ctrl_if.sv
// Byte-port, frame-memory and processing-core signals of multich_xfer_ctrl.
// master = controller side, slave = SPI slave / BRAM / core side.
interface multich_xfer_ctrl_if #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned RES_BYTES = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   rx_dv;
    logic [7:0]             rx_byte;
    logic [7:0]             tx_byte;
    logic [CH_W-1:0]        mem_ch;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_we;
    logic [7:0]             mem_wdata;
    logic [7:0]             mem_rdata;
    logic                   proc_active;
    logic                   proc_done;
    logic [RES_BYTES*8-1:0] result;

    modport master (
        input  rx_dv, rx_byte, mem_rdata, proc_done, result,
        output tx_byte, mem_ch, mem_addr, mem_we, mem_wdata, proc_active
    );

    modport slave (
        output rx_dv, rx_byte, mem_rdata, proc_done, result,
        input  tx_byte, mem_ch, mem_addr, mem_we, mem_wdata, proc_active
    );
endinterface

// File: rtl/multich_xfer_ctrl.sv
// SPI opcode decoder running frame write/read bursts, core start and result readback.
// Define XFER_TIMEOUT_EN to abort stalled WR/RD/RES bursts after TIMEOUT_CYC idle cycles.
module multich_xfer_ctrl #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DEPTH       = 76800,
    parameter int unsigned RES_BYTES   = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    multich_xfer_ctrl_if.master bus,
    output logic [2:0]          state,
    output logic                err
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IDX_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RES_BYTES - 1);
    localparam logic [2:0]        NCH_M1    = 3'(NUM_CH - 1);
    localparam logic [4:0]        NCH5      = 5'(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_PROC = 3'd3,
        ST_RES  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CMD_WR     = 4'd1,
        CMD_RD     = 4'd2,
        CMD_PROC   = 4'd3,
        CMD_STATUS = 4'd4,
        CMD_RES    = 4'd5
    } cmd_t;

    state_t            state_q, state_d;
    logic [7:0]        tx_q, tx_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              proc_q, proc_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              fetch1_q, fetch1_d;
    logic              fetch2_q, fetch2_d;

    cmd_t              cmd;
    logic              ch_bad;
    logic [IDX_W-1:0]  idx_inc;

    assign cmd     = cmd_t'(bus.rx_byte[7:4]);
    assign ch_bad  = ({1'b0, bus.rx_byte[3:0]} >= NCH5);
    assign idx_inc = idx_q + 1'b1;

`ifdef XFER_TIMEOUT_EN
    localparam int unsigned     TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_q, to_d;
`else
    if (TIMEOUT_CYC == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        ch_d     = ch_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        proc_d   = proc_q;
        err_d    = err_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        fetch1_d = 1'b0;
        fetch2_d = fetch1_q;

        // Read data arrives one cycle after the address; fetch2 marks it valid.
        if (fetch2_q) tx_d = bus.mem_rdata;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_dv) begin
                    case (cmd)
                        CMD_WR, CMD_RD: begin
                            if (ch_bad) begin
                                err_d = 1'b1;
                                tx_d  = 8'hEE;
                            end else begin
                                ch_d  = CH_W'(bus.rx_byte[3:0]);
                                cnt_d = '0;
                                if (cmd == CMD_WR) begin
                                    state_d = ST_WR;
                                end else begin
                                    state_d  = ST_RD;
                                    addr_d   = '0;
                                    fetch1_d = 1'b1;
                                end
                            end
                        end
                        CMD_PROC: begin
                            state_d = ST_PROC;
                            proc_d  = 1'b1;
                            tx_d    = 8'hBB;
                        end
                        CMD_STATUS: begin
                            tx_d   = {done_q, err_q, 3'b000, NCH_M1};
                            err_d  = 1'b0;
                            done_d = 1'b0;
                        end
                        CMD_RES: begin
                            state_d = ST_RES;
                            idx_d   = '0;
                            tx_d    = bus.result[7:0];
                        end
                        default: begin
                            err_d = 1'b1;
                            tx_d  = 8'hEE;
                        end
                    endcase
                end
            end
            ST_WR: begin
                // Leave only after the last write strobe so mem_we stays inside WR.
                if (we_q && addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_dv) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = bus.rx_byte;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_RD: begin
                if (bus.rx_dv) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        addr_d   = addr_q + 1'b1;
                        fetch1_d = 1'b1;
                    end
                end
            end
            ST_PROC: begin
                if (bus.proc_done) begin
                    proc_d  = 1'b0;
                    done_d  = 1'b1;
                    tx_d    = 8'hD0;
                    state_d = ST_IDLE;
                end
            end
            ST_RES: begin
                if (bus.rx_dv) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_inc;
                        tx_d  = bus.result[{idx_inc, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef XFER_TIMEOUT_EN
        to_d = '0;
        if ((state_q == ST_WR || state_q == ST_RD || state_q == ST_RES) && !bus.rx_dv) begin
            if (to_q == TO_LAST) begin
                err_d    = 1'b1;
                we_d     = 1'b0;
                fetch1_d = 1'b0;
                state_d  = ST_IDLE;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tx_q     <= '0;
            ch_q     <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            proc_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            fetch1_q <= 1'b0;
            fetch2_q <= 1'b0;
`ifdef XFER_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            ch_q     <= ch_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            proc_q   <= proc_d;
            err_q    <= err_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fetch1_q <= fetch1_d;
            fetch2_q <= fetch2_d;
`ifdef XFER_TIMEOUT_EN
            to_q     <= to_d;
`endif
        end
    end

    assign bus.tx_byte     = tx_q;
    assign bus.mem_ch      = ch_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.proc_active = proc_q;
    assign state           = state_q;
    assign err             = err_q;
endmodule

// File: tb/tb_multich_xfer_ctrl.sv
// Directed bench for multich_xfer_ctrl: write/read bursts, PROC, STATUS, errors, RES, reset.
module tb_multich_xfer_ctrl;
    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned ADDR_W      = 17;
    localparam int unsigned DEPTH       = 16;
    localparam int unsigned RES_BYTES   = 8;
    localparam int unsigned TIMEOUT_CYC = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic       err;

    always #5 clk = ~clk;

    multich_xfer_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RES_BYTES(RES_BYTES)) bus ();

    multich_xfer_ctrl #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .RES_BYTES(RES_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .state(state), .err(err)
    );

    // Frame memory with one-cycle read latency.
    logic [7:0] bram [NUM_CH][DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we) bram[bus.mem_ch][bus.mem_addr[3:0]] <= bus.mem_wdata;
        bus.mem_rdata <= bram[bus.mem_ch][bus.mem_addr[3:0]];
    end

    int checks = 0;
    int errors = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_ch[$];
    int we_long = 0;
    int we_bad  = 0;
    int act_cnt = 0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(int'(bus.mem_addr));
            wr_data.push_back(int'(bus.mem_wdata));
            wr_ch.push_back(int'(bus.mem_ch));
            if (prev_we) we_long++;
            if (state != 3'd1) we_bad++;
        end
        prev_we = bus.mem_we;
        if (bus.proc_active) act_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One SPI byte: returns tx_byte as it stands before the strobe; call at a negedge.
    task automatic xfer(input logic [7:0] b, output logic [7:0] miso);
        miso        = bus.tx_byte;
        bus.rx_byte = b;
        bus.rx_dv   = 1'b1;
        @(negedge clk);
        bus.rx_dv   = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state, 3'd0);
        check({tag, "_tx"}, bus.tx_byte, 8'h00);
        check({tag, "_we"}, bus.mem_we, 1'b0);
        check({tag, "_addr"}, bus.mem_addr, '0);
        check({tag, "_ch"}, bus.mem_ch, '0);
        check({tag, "_wdata"}, bus.mem_wdata, 8'h00);
        check({tag, "_proc"}, bus.proc_active, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bus.rx_dv     = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.proc_done = 1'b0;
        bus.result    = 64'h0807060504030201;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b1;
        @(negedge clk);

        // T1: write burst to channel 1
        xfer(8'h11, d);
        check("wr_state", state, 3'd1);
        for (int i = 0; i < 16; i++) xfer(8'(i), d);
        check("wr_end_state", state, 3'd0);
        check("wr_count", wr_addr.size(), 16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            check("wr_addr", wr_addr[i], i);
            check("wr_data", wr_data[i], i);
            check("wr_ch", wr_ch[i], 1);
        end
        check("we_one_cycle", we_long, 0);
        check("we_outside_wr", we_bad, 0);

        // T2: read the frame back
        xfer(8'h21, d);
        check("rd_state", state, 3'd2);
        for (int i = 0; i < 16; i++) begin
            xfer(8'hA5, d);
            check("rd_byte", d, 8'(i));
        end
        check("rd_end_state", state, 3'd0);
        check("rd_no_write", wr_addr.size(), 16);

        // T3: processing run, stray byte ignored, done beats simultaneous byte
        act_cnt       = 0;
        bus.rx_byte   = 8'h30;
        bus.rx_dv     = 1'b1;
        @(negedge clk);
        bus.rx_dv     = 1'b0;
        check("proc_active", bus.proc_active, 1'b1);
        check("proc_tx", bus.tx_byte, 8'hBB);
        check("proc_state", state, 3'd3);
        for (int i = 2; i <= 50; i++) begin
            @(negedge clk);
            bus.rx_byte   = 8'h11;
            bus.rx_dv     = (i == 10) || (i == 50);
            bus.proc_done = (i == 50);
            if (i == 20) check("proc_ignore_rx", state, 3'd3);
        end
        @(negedge clk);
        bus.rx_dv     = 1'b0;
        bus.proc_done = 1'b0;
        check("proc_fall", bus.proc_active, 1'b0);
        check("proc_done_tx", bus.tx_byte, 8'hD0);
        check("proc_end_state", state, 3'd0);
        check("proc_len", act_cnt, 50);
        repeat (5) @(negedge clk);
        check("proc_no_write", wr_addr.size(), 16);
        xfer(8'h40, d);
        check("status_done", bus.tx_byte, 8'h82);
        xfer(8'h40, d);
        check("status_clr", bus.tx_byte, 8'h02);

        // T4: protocol errors
        xfer(8'h13, d);
        check("bad_ch_err", err, 1'b1);
        check("bad_ch_tx", bus.tx_byte, 8'hEE);
        check("bad_ch_state", state, 3'd0);
        xfer(8'h40, d);
        xfer(8'h90, d);
        check("bad_cmd_err", err, 1'b1);
        check("bad_cmd_tx", bus.tx_byte, 8'hEE);
        check("bad_cmd_state", state, 3'd0);
        xfer(8'h40, d);
        check("status_err", bus.tx_byte, 8'h42);
        check("status_err_clr", err, 1'b0);

        // T5: result readback, LSB byte first
        xfer(8'h50, d);
        check("res_state", state, 3'd4);
        for (int i = 0; i < 8; i++) begin
            xfer(8'h00, d);
            check("res_byte", d, 8'(i + 1));
        end
        check("res_end_state", state, 3'd0);

        // Stalled burst: aborts with the timeout build, waits otherwise
        xfer(8'h10, d);
        repeat (110) @(negedge clk);
`ifdef XFER_TIMEOUT_EN
        check("to_err", err, 1'b1);
        check("to_state", state, 3'd0);
        check("to_we", bus.mem_we, 1'b0);
`else
        check("stall_state", state, 3'd1);
        check("stall_err", err, 1'b0);
        for (int i = 0; i < 16; i++) xfer(8'h5A, d);
        check("stall_end_state", state, 3'd0);
`endif

        // T6: async reset mid-burst keeps partial frame
        xfer(8'h12, d);
        check("wr2_state", state, 3'd1);
        for (int i = 0; i < 5; i++) xfer(8'hC0 + 8'(i), d);
        rst = 1'b0;
        #1;
        check_reset_vals("midwr");
        for (int i = 0; i < 5; i++) check("partial_frame", bram[2][i], 8'hC0 + 8'(i));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset during PROC drops proc_active immediately
        xfer(8'h30, d);
        check("proc2_active", bus.proc_active, 1'b1);
        rst = 1'b0;
        #1;
        check("midproc_proc", bus.proc_active, 1'b0);
        check("midproc_state", state, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
